cas_fsk_player: RTL

Cassette playback stage between the tape-image SRAM and the cassette input. Reads the loaded CAS image byte by byte over the SRAM read port and serialises each byte, LSB first, into the CoCo FSK square wave on `data`: 2400 Hz for a 1 bit, 1200 Hz for a 0 bit. Runs only while the motor relay is closed, stops at end of tape, and returns to byte 0 on rewind. Its output `data` drives the machine's cassette input and the optional tape-monitor audio tap.

---
 rtl/cas_pkg.sv | 18 +
 rtl/cas_half_timer.sv | 33 +++
 rtl/cas_fsk_player.sv | 116 +++++++++++
 3 files changed

// File: rtl/cas_pkg.sv
// Shared types and constants for the cassette FSK playback stage.
// Half-periods are in CoCo Q-rate ticks.
package cas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HIGH,
        LOW,
        END
    } cas_state_t;

    localparam int CNT_W     = 9;
    localparam int HALF1_DEF = 186;
    localparam int HALF0_DEF = 373;
    localparam int Q_RATE_HZ = 894886;

endpackage

// File: rtl/cas_half_timer.sv
// Half-cycle tick counter: freezes while en=0, clears on clr,
// pulses done for one clk after the tick that reaches half.
module cas_half_timer
    import cas_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] half,
    output logic             done
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick && en) begin
                count <= count_inc;
                done  <= (count_inc == half);
            end
        end
    end

endmodule

// File: rtl/cas_fsk_player.sv
// CAS image player: fetches tape bytes from SRAM and emits them
// LSB first as CoCo FSK (short cycle = 1, long cycle = 0).
module cas_fsk_player
    import cas_pkg::*;
#(
    parameter int HALF1  = HALF1_DEF,
    parameter int HALF0  = HALF0_DEF,
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        en,
    input  logic        rewind,
    input  logic [15:0] tape_len,
    output logic [15:0] ram_addr,
    output logic        ram_rd,
    input  logic [7:0]  ram_data,
    output logic        data,
    output logic        active,
    output logic        eot
);

    localparam logic [CNT_W-1:0] H1  = CNT_W'(HALF1);
    localparam logic [CNT_W-1:0] H0  = CNT_W'(HALF0);
    localparam logic [3:0]       LAT = 4'(RD_LAT);

    cas_state_t  state, state_n;
    logic [7:0]  sreg, sreg_n;
    logic [2:0]  bit_idx, idx_n;
    logic [3:0]  lat_cnt, lat_n;
    logic [15:0] addr_n, addr_inc;
    logic        in_bit, done;

    assign in_bit   = (state == HIGH) || (state == LOW);
    assign ram_rd   = (state == FETCH) && (lat_cnt == 4'd0);
    assign data     = (state == HIGH);
    assign active   = in_bit;
    assign eot      = (state == END);
    assign addr_inc = ram_addr + 16'd1;

    cas_half_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (in_bit && en),
        .tick  (tick),
        .clr   (!in_bit || done),
        .half  (sreg[0] ? H1 : H0),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sreg     <= '0;
            bit_idx  <= '0;
            lat_cnt  <= '0;
            ram_addr <= '0;
        end else begin
            state    <= state_n;
            sreg     <= sreg_n;
            bit_idx  <= idx_n;
            lat_cnt  <= lat_n;
            ram_addr <= addr_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        idx_n   = bit_idx;
        lat_n   = lat_cnt;
        addr_n  = ram_addr;
        unique case (state)
            IDLE: begin
                if (tape_len != 16'd0 && en)
                    state_n = FETCH;
            end
            FETCH: begin
                if (lat_cnt == LAT) begin
                    sreg_n  = ram_data;
                    idx_n   = 3'd0;
                    lat_n   = 4'd0;
                    state_n = HIGH;
                end else begin
                    lat_n = lat_cnt + 4'd1;
                end
            end
            HIGH: begin
                if (done)
                    state_n = LOW;
            end
            LOW: begin
                if (done) begin
                    if (bit_idx != 3'd7) begin
                        idx_n   = bit_idx + 3'd1;
                        sreg_n  = {1'b0, sreg[7:1]};
                        state_n = HIGH;
                    end else begin
                        // >= also catches a tape that shrank mid-play
                        addr_n  = addr_inc;
                        state_n = (addr_inc >= tape_len) ? END : FETCH;
                    end
                end
            end
            END: state_n = END;
            default: state_n = IDLE;
        endcase
        if (rewind) begin
            state_n = IDLE;
            addr_n  = '0;
            lat_n   = '0;
        end
    end

endmodule
